calendar_date_counter: RTL

- Sequential date generator that sits directly upstream of the combinational day-of-year calculator (dayOfYrCalc_c).
- Holds the current calendar date (day of month, month, year in 0000..2047) and advances it by one day per tick, applying Gregorian leap rules.
- Accepts a validated parallel load of any date.
- Outputs feed the calculator's dayOfMonth/month/year inputs unchanged in width and range.

---
 rtl/calendar_date_counter_if.sv | 30 +++
 rtl/calendar_date_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/calendar_date_counter_if.sv
`default_nettype none
// ============================================================================
// calendar_date_counter_if : control/load inputs and date outputs of the counter
// Rev 1.0
// ============================================================================
interface calendar_date_counter_if;
  logic        tick;
  logic        load;
  logic [5:0]  load_day;
  logic [3:0]  load_month;
  logic [10:0] load_year;
  logic [5:0]  dayOfMonth;
  logic [3:0]  month;
  logic [10:0] year;
  logic        leap;
  logic        new_day;
  logic        wrap;
  logic        load_err;

  modport master (
    output tick, load, load_day, load_month, load_year,
    input  dayOfMonth, month, year, leap, new_day, wrap, load_err
  );

  modport slave (
    input  tick, load, load_day, load_month, load_year,
    output dayOfMonth, month, year, leap, new_day, wrap, load_err
  );
endinterface
`default_nettype wire

// File: rtl/calendar_date_counter.sv
`default_nettype none
// ============================================================================
// calendar_date_counter : Gregorian date register advanced one day per tick
// Rev 1.0
// ============================================================================
module calendar_date_counter #(
  parameter int MAX_YEAR   = 2047,
  parameter int RESET_YEAR = 0
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  calendar_date_counter_if.slave  bus
);

  localparam logic [10:0] c_max_year   = 11'(MAX_YEAR);
  localparam logic [10:0] c_reset_year = 11'(RESET_YEAR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADV  = 2'd1,
    S_LD   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  r_day;
  logic [3:0]  r_month;
  logic [10:0] r_year;
  logic        r_leap;
  logic        r_new_day;
  logic        r_wrap;
  logic        r_load_err;

  logic [5:0]  w_day_nxt;
  logic [3:0]  w_month_nxt;
  logic [10:0] w_year_nxt;
  logic        w_wrap_nxt;
  logic        w_load_valid;
  logic [5:0]  w_cur_len;
  logic [5:0]  w_load_len;

  function automatic logic f_leap(input logic [10:0] y);
    return ((y % 11'd4) == 11'd0) &&
           (((y % 11'd100) != 11'd0) || ((y % 11'd400) == 11'd0));
  endfunction

  function automatic logic [5:0] f_month_len(input logic [3:0] m, input logic lp);
    logic [5:0] len;
    case (m)
      4'd2:                      len = lp ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   len = 6'd30;
      default:                   len = 6'd31;
    endcase
    return len;
  endfunction

  assign w_cur_len  = f_month_len(r_month, r_leap);
  // Load length uses the leap status of the year being loaded, not the current one.
  assign w_load_len = f_month_len(bus.load_month, f_leap(bus.load_year));

  assign w_load_valid = (bus.load_month >= 4'd1) && (bus.load_month <= 4'd12) &&
                        (bus.load_year <= c_max_year) &&
                        (bus.load_day != 6'd0) && (bus.load_day <= w_load_len);

  always_comb begin
    w_state_nxt = S_IDLE;
    w_day_nxt   = r_day;
    w_month_nxt = r_month;
    w_year_nxt  = r_year;
    w_wrap_nxt  = 1'b0;

    if (bus.load) begin
      if (w_load_valid) begin
        w_state_nxt = S_LD;
        w_day_nxt   = bus.load_day;
        w_month_nxt = bus.load_month;
        w_year_nxt  = bus.load_year;
      end else begin
        w_state_nxt = S_ERR;
      end
    end else if (bus.tick) begin
      w_state_nxt = S_ADV;
      if (r_day < w_cur_len) begin
        w_day_nxt = r_day + 6'd1;
      end else begin
        w_day_nxt = 6'd1;
        if (r_month == 4'd12) begin
          w_month_nxt = 4'd1;
          if (r_year == c_max_year) begin
            w_year_nxt = 11'd0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_year_nxt = r_year + 11'd1;
          end
        end else begin
          w_month_nxt = r_month + 4'd1;
        end
      end
    end
  end

  // Pulse flops follow the next state so each output is a plain register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_day      <= 6'd1;
      r_month    <= 4'd1;
      r_year     <= c_reset_year;
      r_leap     <= f_leap(c_reset_year);
      r_new_day  <= 1'b0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_day      <= w_day_nxt;
      r_month    <= w_month_nxt;
      r_year     <= w_year_nxt;
      r_leap     <= f_leap(w_year_nxt);
      r_new_day  <= (w_state_nxt == S_ADV);
      r_wrap     <= w_wrap_nxt;
      r_load_err <= (w_state_nxt == S_ERR);
    end
  end

  assign bus.dayOfMonth = r_day;
  assign bus.month      = r_month;
  assign bus.year       = r_year;
  assign bus.leap       = r_leap;
  assign bus.new_day    = r_new_day;
  assign bus.wrap       = r_wrap;
  assign bus.load_err   = r_load_err;

endmodule
`default_nettype wire
